// File: rtl/seq_divider_64.sv
// Iterative unsigned restoring divider: one shift/trial-subtract step per
// clock, start/done handshake, results held until the next done.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating, one quotient bit per clock (busy=1)
// DONE  | one-cycle done pulse; accepts a new start like IDLE
module seq_divider_64 #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // The partial remainder is always below the divisor between steps, so only
  // its low WIDTH bits need storing; the extra bit exists only in the
  // shifted/trial values below.
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     a_sh;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   a_nxt;
  logic [WIDTH-1:0]   q_nxt;

  // One restoring step: shift {A,Q} left, trial-subtract D, keep if non-negative.
  always_comb begin
    a_sh  = {a_q, q_q[WIDTH-1]};
    trial = a_sh - {1'b0, d_q};
    if (!trial[WIDTH]) begin
      a_nxt = trial[WIDTH-1:0];
      q_nxt = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      a_nxt = a_sh[WIDTH-1:0];
      q_nxt = {q_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor != '0) begin
            state_d = CALC;
            a_d     = '0;
            q_d     = dividend;
            d_d     = divisor;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
        end
      end
      CALC: begin
        a_d   = a_nxt;
        q_d   = q_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          quo_d   = q_nxt;
          rem_d   = a_nxt;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_64.sv
// Bench for seq_divider_64: directed vector table, handshake corner cases,
// and random operands against a plain-arithmetic reference.
module tb_seq_divider_64;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_divider_64 dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present operands with start for one cycle; return edges from the
  // accepting edge (edge 1) to the edge that raised done, and busy cycles seen.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        output int edges, output int busy_cnt);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom();
    divisor  = $urandom();
    edges    = 1;
    busy_cnt = 0;
    while (!done && edges < 200) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  function automatic logic [63:0] ref_q(input logic [63:0] a, input logic [63:0] b);
    return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
  endfunction

  function automatic logic [63:0] ref_r(input logic [63:0] a, input logic [63:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  initial begin
    int edges, bcnt, ndone, first_done;
    logic [63:0] ra, rb;

    vecs[0] = '{64'd100, 64'd7, 64'd14, 64'd2, 1'b0};
    vecs[1] = '{64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
    vecs[3] = '{64'd3, 64'd10, 64'd0, 64'd3, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 1'b0};
    vecs[5] = '{64'd0, 64'd3, 64'd0, 64'd0, 1'b0};
    vecs[6] = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 1'b0};

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_q", quotient, 64'd0);
    chk("reset_r", remainder, 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, edges, bcnt);
      chk($sformatf("vec%0d_edges", i), 64'(edges), vecs[i].z ? 64'd1 : 64'd65);
      chk($sformatf("vec%0d_busy", i), 64'(bcnt), vecs[i].z ? 64'd0 : 64'd64);
      chk($sformatf("vec%0d_q", i), quotient, vecs[i].q);
      chk($sformatf("vec%0d_r", i), remainder, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].z));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_pulse", i), 64'(done), 64'd0);
    end

    // start while busy must be ignored
    @(negedge clk);
    dividend = 64'd1000; divisor = 64'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first_done = 0;
    for (int e = 1; e <= 72; e++) begin
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = e;
        if (ndone == 1) begin
          chk("ign_q", quotient, 64'd333);
          chk("ign_r", remainder, 64'd1);
        end
      end
      if (e == 19) begin
        @(negedge clk);
        dividend = 64'd9; divisor = 64'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("ign_done_edge", 64'(first_done), 64'd65);
    chk("ign_done_count", 64'(ndone), 64'd1);

    // back-to-back: start held high, second op accepted in the DONE cycle
    @(negedge clk);
    dividend = 64'd50; divisor = 64'd5; start = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("b2b_first_edge", 64'(edges), 64'd65);
    chk("b2b_first_q", quotient, 64'd10);
    chk("b2b_first_r", remainder, 64'd0);
    dividend = 64'd49;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept_busy", 64'(busy), 64'd1);
    edges = 1;
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("b2b_second_edge", 64'(edges), 64'd65);
    chk("b2b_second_q", quotient, 64'd9);
    chk("b2b_second_r", remainder, 64'd4);

    // reset mid-operation
    @(negedge clk);
    dividend = 64'd77; divisor = 64'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (28) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_q", quotient, 64'd0);
    chk("rst_mid_r", remainder, 64'd0);
    chk("rst_mid_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(64'd20, 64'd6, edges, bcnt);
    chk("post_rst_edges", 64'(edges), 64'd65);
    chk("post_rst_q", quotient, 64'd3);
    chk("post_rst_r", remainder, 64'd2);

    // random operands against the arithmetic reference
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if (i % 8 == 7) rb = '0;
      run_op(ra, rb, edges, bcnt);
      chk($sformatf("rnd%0d_edges", i), 64'(edges), (rb == 0) ? 64'd1 : 64'd65);
      chk($sformatf("rnd%0d_q", i), quotient, ref_q(ra, rb));
      chk($sformatf("rnd%0d_r", i), remainder, ref_r(ra, rb));
      chk($sformatf("rnd%0d_dbz", i), 64'(div_by_zero), (rb == 0) ? 64'd1 : 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
